// File: rtl/ctrl_pipe_chain_pkg.sv
// ctrl_pipe_chain_pkg
//   Shared constants for the control-signal pipeline: stage indices,
//   control-word field offsets and the default write-enable field mask.
package ctrl_pipe_chain_pkg;

  localparam int CTRL_W = 18;

  // stage indices for the default three-stage E/M/W pipe
  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  // control-word field offsets
  localparam int OFF_ALUOP     = 0;   // 4 bits
  localparam int OFF_SRCSEL    = 4;   // 2 bits
  localparam int OFF_MEMWRITE  = 6;   // 1 bit, write enable
  localparam int OFF_REGWRITE  = 7;   // 1 bit, write enable
  localparam int OFF_RESULTSRC = 8;   // 2 bits
  localparam int OFF_BRANCH    = 10;  // 1 bit
  localparam int OFF_IMMSEL    = 11;  // 3 bits
  localparam int OFF_MISC      = 14;  // 4 bits

  localparam logic [CTRL_W-1:0] WE_MASK_DEF =
    (CTRL_W'(1) << OFF_MEMWRITE) | (CTRL_W'(1) << OFF_REGWRITE);

endpackage

// File: rtl/ctrl_pipe_chain_stage_reg.sv
// ctrl_stage_reg
//   One pipeline stage: W-bit control word plus valid bit.
//   Update priority: reset, kill, hold, bubble, load.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   kill         clear word and valid (beats hold)
//   hold         keep current contents
//   bubble       load word 0 / valid 0 instead of d/vd
//   d, vd        incoming word and valid
//   q, vq        registered word and valid
module ctrl_stage_reg
  import ctrl_pipe_chain_pkg::*;
#(
  parameter int W = CTRL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kill,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  input  logic         vd,
  output logic [W-1:0] q,
  output logic         vq
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q  <= '0;
      vq <= 1'b0;
    end else if (kill) begin
      q  <= '0;
      vq <= 1'b0;
    end else if (hold) begin
      q  <= q;
      vq <= vq;
    end else if (bubble) begin
      q  <= '0;
      vq <= 1'b0;
    end else begin
      q  <= d;
      vq <= vd;
    end
  end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain
//   Parametrised control-word pipeline (stage 0 = E) with stall-driven
//   hold/back-pressure, bubble insertion, per-stage flush and a
//   precise-exception kill that also masks write-enable bits.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   ctrl_in      control word from decode
//   valid_in     decode presents a real instruction
//   ready_in     stage 0 accepts this cycle
//   stall_req    per-stage stall request
//   flush_req    per-stage flush request
//   excpt        exception detected at stage EXC_STAGE
//   ctrl_out     flattened stage words, stage i at [i*W +: W]
//   valid_out    per-stage valid
//   inflight     number of valid stages
//   stall_cnt    saturating count of cycles with stage 0 held
module ctrl_pipe_chain
  import ctrl_pipe_chain_pkg::*;
#(
  parameter int           W         = CTRL_W,
  parameter int           STAGES    = 3,
  parameter int           EXC_STAGE = STG_M,
  parameter logic [W-1:0] WE_MASK   = '0,
  parameter int           CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 ctrl_in,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic [STAGES-1:0]            stall_req,
  input  logic [STAGES-1:0]            flush_req,
  input  logic                         excpt,
  output logic [STAGES*W-1:0]          ctrl_out,
  output logic [STAGES-1:0]            valid_out,
  output logic [$clog2(STAGES+1)-1:0]  inflight,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int IW = $clog2(STAGES+1);

  logic [STAGES-1:0] holdVec;
  logic [STAGES-1:0] killVec;
  logic [W-1:0]      stageWord [STAGES];
  logic [STAGES-1:0] stageValid;

  // a stall propagates back-pressure to every stage behind it
  always_comb begin
    holdVec = '0;
    holdVec[STAGES-1] = stall_req[STAGES-1];
    for (int i = STAGES-2; i >= 0; i--) begin
      holdVec[i] = stall_req[i] | holdVec[i+1];
    end
  end

  assign ready_in = ~holdVec[0];

  for (genvar g = 0; g < STAGES; g++) begin : gStage
    logic [W-1:0] dWord;
    logic         dValid;
    logic         bubble;
    logic [W-1:0] weGate;

    assign killVec[g] = flush_req[g] | (excpt & (g <= EXC_STAGE));

    if (g == 0) begin : gHead
      assign dWord  = valid_in ? ctrl_in : '0;
      assign dValid = valid_in;
      assign bubble = 1'b0;
    end else begin : gBody
      assign dWord  = stageWord[g-1];
      assign dValid = stageValid[g-1];
      // held source while this stage advances; hold itself wins inside the reg
      assign bubble = holdVec[g-1];
    end

    ctrl_stage_reg #(.W(W)) uStage (
      .clk    (clk),
      .rst    (rst),
      .kill   (killVec[g]),
      .hold   (holdVec[g]),
      .bubble (bubble),
      .d      (dWord),
      .vd     (dValid),
      .q      (stageWord[g]),
      .vq     (stageValid[g])
    );

    assign weGate = (!stageValid[g] || ((g == EXC_STAGE) && excpt)) ? WE_MASK : '0;
    assign ctrl_out[g*W +: W] = stageWord[g] & ~weGate;
  end

  assign valid_out = stageValid;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflight = inflight + IW'(stageValid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (holdVec[0] && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
module tb_ctrl_pipe_chain;
  import ctrl_pipe_chain_pkg::*;

  localparam int           W     = 18;
  localparam int           NS    = 3;
  localparam int           EXC   = 1;
  localparam logic [W-1:0] WEM   = WE_MASK_DEF;
  localparam int           CNT_W = 4;
  localparam int           CMAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [W-1:0]        ctrl_in;
  logic                valid_in;
  logic                ready_in;
  logic [NS-1:0]       stall_req;
  logic [NS-1:0]       flush_req;
  logic                excpt;
  logic [NS*W-1:0]     ctrl_out;
  logic [NS-1:0]       valid_out;
  logic [1:0]          inflight;
  logic [CNT_W-1:0]    stall_cnt;

  int checks = 0;
  int failures = 0;

  // reference state
  logic [W-1:0] mWord  [NS];
  logic         mValid [NS];
  int           mCnt;

  always #5 clk = ~clk;

  ctrl_pipe_chain #(
    .W(W), .STAGES(NS), .EXC_STAGE(EXC), .WE_MASK(WEM), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_in   (ctrl_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .stall_req (stall_req),
    .flush_req (flush_req),
    .excpt     (excpt),
    .ctrl_out  (ctrl_out),
    .valid_out (valid_out),
    .inflight  (inflight),
    .stall_cnt (stall_cnt)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // a stage is held when it or any stage downstream of it stalls
  function automatic bit isHeld(int i);
    return ((stall_req >> i) != 0);
  endfunction

  task automatic modelStep();
    logic [W-1:0] nWord  [NS];
    logic         nValid [NS];
    for (int i = 0; i < NS; i++) begin
      if (!rst || flush_req[i] || (excpt && i <= EXC)) begin
        nWord[i] = '0; nValid[i] = 1'b0;
      end else if (isHeld(i)) begin
        nWord[i] = mWord[i]; nValid[i] = mValid[i];
      end else if (i == 0) begin
        nWord[i] = valid_in ? ctrl_in : '0; nValid[i] = valid_in;
      end else if (isHeld(i-1)) begin
        nWord[i] = '0; nValid[i] = 1'b0;
      end else begin
        nWord[i] = mWord[i-1]; nValid[i] = mValid[i-1];
      end
    end
    if (!rst) mCnt = 0;
    else if (isHeld(0) && mCnt < CMAX) mCnt++;
    for (int i = 0; i < NS; i++) begin
      mWord[i] = nWord[i]; mValid[i] = nValid[i];
    end
  endtask

  task automatic checkAll();
    logic [NS*W-1:0] expOut;
    logic [NS-1:0]   expValid;
    int              expCount;
    expCount = 0;
    for (int i = 0; i < NS; i++) begin
      logic [W-1:0] w;
      w = mWord[i];
      if (!mValid[i] || (i == EXC && excpt)) w = w & ~WEM;
      expOut[i*W +: W] = w;
      expValid[i] = mValid[i];
      if (mValid[i]) expCount++;
    end
    checkVal("ctrl_out", 64'(ctrl_out), 64'(expOut));
    checkVal("valid_out", 64'(valid_out), 64'(expValid));
    checkVal("inflight", 64'(inflight), 64'(expCount));
    checkVal("ready_in", 64'(ready_in), 64'(!isHeld(0)));
    checkVal("stall_cnt", 64'(stall_cnt), 64'(mCnt));
  endtask

  task automatic runCycle();
    #1;
    checkAll();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idleInputs();
    ctrl_in = '0; valid_in = 1'b0; stall_req = '0; flush_req = '0; excpt = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin mWord[i] = '0; mValid[i] = 1'b0; end
    mCnt = 0;
    idleInputs();
    rst = 1'b0;
    @(posedge clk); modelStep(); #1;
    rst = 1'b1;

    // reset state
    checkVal("rst_valid", 64'(valid_out), 64'(0));
    checkVal("rst_out", 64'(ctrl_out), 64'(0));
    checkVal("rst_cnt", 64'(stall_cnt), 64'(0));

    // stream 1,2,3
    valid_in = 1'b1;
    ctrl_in = 18'h1; runCycle();
    checkVal("lat_s0", 64'(ctrl_out[0 +: W]), 64'(1));
    ctrl_in = 18'h2; runCycle();
    ctrl_in = 18'h3; runCycle();
    checkVal("lat_s2", 64'(ctrl_out[2*W +: W]), 64'(1));
    checkVal("lat_s0_3", 64'(ctrl_out[0 +: W]), 64'(3));
    checkVal("lat_infl", 64'(inflight), 64'(3));

    // stall middle stage for two cycles
    ctrl_in = 18'h4; stall_req = 3'b010;
    runCycle(); runCycle();
    checkVal("stall_valid", 64'(valid_out), 64'(3'b011));
    checkVal("stall_s2", 64'(ctrl_out[2*W +: W]), 64'(0));
    checkVal("stall_ready", 64'(ready_in), 64'(0));
    checkVal("stall_cnt2", 64'(stall_cnt), 64'(2));
    stall_req = '0;

    // exception with a full pipe carrying WE bits
    ctrl_in = 18'h0C5;
    runCycle(); runCycle(); runCycle();
    excpt = 1'b1;
    #1;
    checkVal("exc_we_s1", 64'(ctrl_out[W +: W] & WEM), 64'(0));
    checkVal("exc_nonwe_s1", 64'(ctrl_out[W +: W]), 64'(18'h005));
    runCycle();
    excpt = 1'b0; valid_in = 1'b0;
    #1;
    checkVal("exc_valid", 64'(valid_out), 64'(3'b100));

    // flush beats stall on stage 0
    valid_in = 1'b1; ctrl_in = 18'h2A;
    runCycle(); runCycle(); runCycle();
    flush_req = 3'b001; stall_req = 3'b001;
    runCycle();
    checkVal("flush_valid", 64'(valid_out), 64'(3'b100));
    checkVal("flush_s2", 64'(ctrl_out[2*W +: W]), 64'(18'h2A));
    flush_req = '0; stall_req = '0;

    // reset mid-stream with stalls active
    runCycle(); runCycle();
    stall_req = 3'b011; runCycle();
    rst = 1'b0; runCycle();
    rst = 1'b1;
    #1;
    checkVal("mrst_valid", 64'(valid_out), 64'(0));
    checkVal("mrst_out", 64'(ctrl_out), 64'(0));
    checkVal("mrst_cnt", 64'(stall_cnt), 64'(0));

    // counter saturation
    stall_req = 3'b001;
    for (int i = 0; i < CMAX + 6; i++) runCycle();
    checkVal("sat_cnt", 64'(stall_cnt), 64'(CMAX));
    stall_req = '0;
    rst = 1'b0; runCycle(); rst = 1'b1;

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      ctrl_in  = W'($urandom);
      valid_in = ($urandom_range(3) != 0);
      for (int i = 0; i < NS; i++) begin
        stall_req[i] = ($urandom_range(5) == 0);
        flush_req[i] = ($urandom_range(9) == 0);
      end
      excpt = ($urandom_range(9) == 0);
      rst   = ($urandom_range(59) != 0);
      if (n % 200 < 30) stall_req[0] = 1'b1;
      runCycle();
    end
    idleInputs();
    runCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
- Parametrised control-signal pipeline: carries decoded control words from decode through STAGES register stages (E, M, W for the default of 3).
- Each stage has a valid bit, stall-driven hold and back-pressure, and bubble insertion. Flush requests are per stage.
- A precise-exception kill clears every stage up to a chosen stage and combinationally masks that stage's write-enable bits.
- Sits between the decoders and the datapath; generalises the fixed E/M/W control registers to any width and depth, with stall-aware bubbles and per-stage flush.

Parameters:
- W, 18, control word width in bits.
- STAGES, 3, number of pipeline stages (min 2); stage 0 is E.
- EXC_STAGE, 1, stage index at which exceptions are detected (0..STAGES-1).
- WE_MASK, 18'h0, bit mask of write-enable fields within the control word; these bits are gated by valid and exception.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- ctrl_in  in  W  control word from decode.
- valid_in  in  1  decode presents a real instruction.
- ready_in  out  1  stage 0 accepts this cycle (= ~hold[0]).
- stall_req  in  STAGES  bit i: stage i must hold its contents.
- flush_req  in  STAGES  bit i: clear stage i at next edge.
- excpt  in  1  exception at stage EXC_STAGE.
- ctrl_out  out  STAGES*W  flattened stage words, stage i at [i*W +: W].
- valid_out  out  STAGES  per-stage valid.
- inflight  out  $clog2(STAGES+1)  count of valid stages (combinational popcount).
- stall_cnt  out  CNT_W  saturating count of cycles with hold[0]=1.

Behaviour:
- Reset (rst=0 at an edge): all stage words and valid bits become 0, stall_cnt becomes 0. Reset overrides every other input.
- Hold chain:
  - hold[STAGES-1] = stall_req[STAGES-1].
  - hold[i] = stall_req[i] | hold[i+1].
- Stage update priority, per stage i per edge, highest first:
  - reset;
  - kill, where kill[i] = flush_req[i] | (excpt & i<=EXC_STAGE): word and valid become 0;
  - hold[i]: retain contents;
  - otherwise load from the source (stage i-1, or ctrl_in/valid_in for i=0).
  - If the source stage is held (hold[i-1]=1) while stage i advances, stage i loads a bubble (word 0, valid 0).
- Kill beats hold: a flushed stage clears even while stalled.
- Stage 0 with valid_in=0 loads a word of 0.
- Latency: ctrl_in is visible at stage 0 one cycle after acceptance, and at stage k after k+1 cycles with no stalls.
- Output masking, combinational:
  - Bits in WE_MASK of ctrl_out stage i are forced 0 when valid_out[i]=0.
  - They are also forced 0 for stage EXC_STAGE while excpt=1.
  - Non-WE bits pass unchanged.
- Last stage has no downstream hold; its word is consumed every cycle it is not stalled.
- stall_cnt increments each cycle hold[0]=1 and saturates at all-ones.
- Simultaneous excpt and stall_req: the kill applies and the stages behind the stall are still held.
- valid_in is ignored when ready_in=0; decode must present the same word again.

Decomposition:
- Shared package: stage index constants (STG_E=0, STG_M=1, STG_W=2), default WE_MASK bit positions of the memwrite and regwrite fields, and the control-word field offsets.
- One sub-module, ctrl_stage_reg: a W+1 bit register with synchronous active-low reset and inputs kill, hold, bubble, d, vd.
- The top instantiates STAGES copies of ctrl_stage_reg via generate, and contains the hold chain, output masking and counters.

Test Plan:
- Reset, then stream words 0x01, 0x02, 0x03 with valid_in=1 → stage 0 shows 0x01 at cycle 1; stage 2 shows 0x01 at cycle 3; inflight=3 at cycle 3.
- stall_req=3'b010 for 2 cycles with a full pipe → stages 0-1 hold, stage 2 gets bubbles (valid 0, word 0), ready_in=0, stall_cnt=2.
- excpt=1 with EXC_STAGE=1 while stages 0-2 are valid → next cycle valid_out=3'b100, and during the excpt cycle stage 1 WE bits read 0.
- flush_req=3'b001 together with stall_req=3'b001 → stage 0 clears despite the hold; stages 1-2 unaffected except stage 1 receives a bubble.
- rst=0 for one cycle mid-stream with stalls active → all valid 0, ctrl_out 0, stall_cnt 0 on the next cycle.
- Hold stall_req[0]=1 for 2^CNT_W+5 cycles (CNT_W=4) → stall_cnt saturates at 0xF.
